// File: rtl/bmp_cmd_sequencer.sv
// Command FIFO and issue sequencer for the BMP/font placer.
// Pops one command per placer idle period and drives a single-cycle pulse.
module bmp_cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_wr,
  input  logic [31:0]   cmd_data,
  input  logic          clr_ovf,
  input  logic          pl_idle,
  output logic          add_img,
  output logic          rem_img,
  output logic          add_fnt,
  output logic [4:0]    image_indx,
  output logic [5:0]    fnt_indx,
  output logic [9:0]    xloc,
  output logic [8:0]    yloc,
  output logic [AW:0]   cmd_cnt,
  output logic          cmd_full,
  output logic          cmd_empty,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI
  } state_t;

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  // Reserved bits [23:19] are not stored.
  logic [26:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  state_t        r_state;
  logic          r_ovf;
  logic          r_add;
  logic          r_rem;
  logic          r_fnt;
  logic [5:0]    r_indx;
  logic [9:0]    r_x;
  logic [8:0]    r_y;

  logic [26:0]   w_head;
  logic [1:0]    w_op;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_unused;

  assign w_unused = ^cmd_data[23:19];
  assign w_head   = r_mem[r_rptr];
  assign w_op     = w_head[26:25];
  assign w_full   = (r_cnt == LP_FULL);
  assign w_empty  = (r_cnt == '0);
  assign w_pop    = (r_state == S_IDLE) && !w_empty && pl_idle;
  assign w_push   = cmd_wr && (!w_full || w_pop);
  assign w_drop   = cmd_wr && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {cmd_data[31:24], cmd_data[18:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_state <= S_IDLE;
      r_add   <= 1'b0;
      r_rem   <= 1'b0;
      r_fnt   <= 1'b0;
      r_indx  <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - (AW+1)'(1);

      if (w_drop)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;

      r_add <= 1'b0;
      r_rem <= 1'b0;
      r_fnt <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_indx <= w_head[24:19];
            r_y    <= w_head[18:10];
            r_x    <= w_head[9:0];
            if (w_op != 2'b11) begin
              r_state <= S_ISSUE;
              r_add   <= (w_op == 2'b00);
              r_rem   <= (w_op == 2'b01);
              r_fnt   <= (w_op == 2'b10);
            end
          end
        end
        S_ISSUE:   r_state <= S_WAIT_LO;
        // Wait for the placer to leave idle before trusting pl_idle.
        S_WAIT_LO: if (!pl_idle) r_state <= S_WAIT_HI;
        S_WAIT_HI: if (pl_idle)  r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign add_img    = r_add;
  assign rem_img    = r_rem;
  assign add_fnt    = r_fnt;
  assign image_indx = r_indx[4:0];
  assign fnt_indx   = r_indx;
  assign xloc       = r_x;
  assign yloc       = r_y;
  assign cmd_cnt    = r_cnt;
  assign cmd_full   = w_full;
  assign cmd_empty  = w_empty;
  assign ovf        = r_ovf;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_bmp_cmd_sequencer.sv
// Bench for bmp_cmd_sequencer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bmp_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_wr;
  logic [31:0] cmd_data;
  logic        clr_ovf;
  logic        pl_idle;
  logic        add_img;
  logic        rem_img;
  logic        add_fnt;
  logic [4:0]  image_indx;
  logic [5:0]  fnt_indx;
  logic [9:0]  xloc;
  logic [8:0]  yloc;
  logic [4:0]  cmd_cnt;
  logic        cmd_full;
  logic        cmd_empty;
  logic        ovf;
  logic        busy;

  bmp_cmd_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .clr_ovf(clr_ovf), .pl_idle(pl_idle),
    .add_img(add_img), .rem_img(rem_img), .add_fnt(add_fnt),
    .image_indx(image_indx), .fnt_indx(fnt_indx),
    .xloc(xloc), .yloc(yloc), .cmd_cnt(cmd_cnt),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty),
    .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: the queue holds pending words; a command is
  // "in flight" from its pop until the placer has gone busy and
  // come back idle.
  logic [31:0] q[$];
  bit          m_on = 0;
  bit          inflight, issued, seen_low, take, full0;
  logic [2:0]  m_pulse;
  logic [5:0]  m_ix;
  logic [9:0]  m_x;
  logic [8:0]  m_y;
  bit          m_ovf;
  logic [31:0] w;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_on = 1; inflight = 0; issued = 0; seen_low = 0;
      m_pulse = '0; m_ix = '0; m_x = '0; m_y = '0; m_ovf = 0;
    end else if (m_on) begin
      full0 = (q.size() == 16);
      take  = !inflight && (q.size() != 0) && pl_idle;
      m_pulse = '0;
      if (inflight) begin
        if (!issued) issued = 1;
        else if (!seen_low) begin
          if (!pl_idle) seen_low = 1;
        end else if (pl_idle) inflight = 0;
      end
      if (take) begin
        w = q.pop_front();
        m_x = w[9:0]; m_y = w[18:10]; m_ix = w[29:24];
        if (w[31:30] != 2'b11) begin
          inflight = 1; issued = 0; seen_low = 0;
          m_pulse[w[31:30]] = 1'b1;
        end
      end
      if (cmd_wr && (!full0 || take)) q.push_back(cmd_data);
      if (cmd_wr && full0 && !take) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  function automatic logic [41:0] exp_vec();
    logic [4:0] c;
    c = 5'(q.size());
    return {m_pulse[0], m_pulse[1], m_pulse[2], m_ix[4:0], m_ix,
            m_x, m_y, c, c == 5'd16, c == 5'd0, m_ovf,
            inflight || (c != 5'd0)};
  endfunction

  always @(negedge clk) begin
    if (m_on)
      chk("cycle", {add_img, rem_img, add_fnt, image_indx, fnt_indx,
                    xloc, yloc, cmd_cnt, cmd_full, cmd_empty, ovf, busy},
          exp_vec());
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] ix;
    logic [9:0] x;
  } ent_t;
  ent_t log_q[$];

  always @(negedge clk) begin
    if (add_img) log_q.push_back('{2'd0, fnt_indx, xloc});
    if (rem_img) log_q.push_back('{2'd1, fnt_indx, xloc});
    if (add_fnt) log_q.push_back('{2'd2, fnt_indx, xloc});
  end

  // Placer stand-in: goes busy for bt cycles after each pulse.
  task automatic placer(input int bt, input int ncyc);
    int left;
    left = 0;
    pl_idle = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (left > 0) begin
        left--;
        if (left == 0) pl_idle = 1'b1;
      end else if (add_img || rem_img || add_fnt) begin
        pl_idle = 1'b0;
        left = bt;
      end
      @(negedge clk);
    end
    pl_idle = 1'b1;
  endtask

  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    cmd_wr = 1'b1;
    cmd_data = d;
  endtask

  initial begin
    rst = 1'b1; cmd_wr = 1'b0; cmd_data = '0;
    clr_ovf = 1'b0; pl_idle = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", cmd_empty, 1);
    chk("rst_full", cmd_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {add_img, rem_img, add_fnt}, 0);

    // single image: op 00, indx 1, reserved bit set, y 7, x 12
    wr(32'h0108_1C0C);
    @(negedge clk); cmd_wr = 1'b0;
    chk("img_c1", add_img, 0);
    @(negedge clk);
    chk("img_c2", add_img, 1);
    chk("img_indx", image_indx, 1);
    chk("img_x", xloc, 12);
    chk("img_y", yloc, 7);
    pl_idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) chk("img_c3", add_img, 0);
    end
    pl_idle = 1'b1;
    chk("img_busy_hi", busy, 1);
    @(negedge clk);
    chk("img_busy_lo", busy, 0);

    // font string
    log_q.delete();
    pl_idle = 1'b0;
    for (int i = 0; i < 3; i++)
      wr({2'b10, 6'(10 + i), 5'd0, 9'd3, 10'(14 * i)});
    @(negedge clk); cmd_wr = 1'b0;
    placer(4, 60);
    chk("fnt_count", log_q.size(), 3);
    foreach (log_q[i]) begin
      chk("fnt_op", log_q[i].op, 2);
      chk("fnt_indx", log_q[i].ix, 10 + i);
      chk("fnt_x", log_q[i].x, 14 * i);
    end
    chk("fnt_idle", busy, 0);

    // fill and overflow
    log_q.delete();
    pl_idle = 1'b0;
    for (int i = 0; i < 17; i++)
      wr({2'b00, 6'(i), 5'd0, 9'(i), 10'(i)});
    @(negedge clk); cmd_wr = 1'b0;
    chk("ovf_cnt", cmd_cnt, 16);
    chk("ovf_full", cmd_full, 1);
    chk("ovf_flag", ovf, 1);
    placer(3, 200);
    chk("ovf_pulses", log_q.size(), 16);
    if (log_q.size() == 16) chk("ovf_last", log_q[15].ix, 15);
    chk("ovf_sticky", ovf, 1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);

    // write while full with simultaneous pop
    log_q.delete();
    pl_idle = 1'b0;
    for (int i = 0; i < 16; i++)
      wr({2'b00, 6'(i), 5'd0, 9'd1, 10'(i)});
    @(negedge clk);
    chk("wfp_full", cmd_cnt, 16);
    pl_idle = 1'b1;
    cmd_data = {2'b00, 6'd40, 5'd0, 9'd2, 10'd40};
    @(negedge clk); cmd_wr = 1'b0;
    chk("wfp_cnt", cmd_cnt, 16);
    chk("wfp_ovf", ovf, 0);
    placer(3, 200);
    chk("wfp_pulses", log_q.size(), 17);
    if (log_q.size() == 17) chk("wfp_last", log_q[16].ix, 40);

    // nop, remove, nop
    log_q.delete();
    pl_idle = 1'b0;
    wr(32'hC3FF_FFFF);
    wr({2'b01, 6'd2, 5'h1F, 9'd100, 10'd200});
    wr(32'hC000_0000);
    @(negedge clk); cmd_wr = 1'b0;
    pl_idle = 1'b1;
    @(negedge clk);
    chk("nop_cnt1", cmd_cnt, 2);
    chk("nop_x", xloc, 10'h3FF);
    @(negedge clk);
    chk("rem_pulse", rem_img, 1);
    chk("rem_x", xloc, 200);
    chk("rem_cnt", cmd_cnt, 1);
    pl_idle = 1'b0;
    @(negedge clk);
    @(negedge clk); pl_idle = 1'b1;
    @(negedge clk);
    chk("nop_cnt2", cmd_cnt, 1);
    @(negedge clk);
    chk("nop_empty", cmd_empty, 1);
    chk("nop_busy", busy, 0);
    chk("rem_count", log_q.size(), 1);

    // reset while waiting on the placer
    pl_idle = 1'b0;
    for (int i = 0; i < 6; i++)
      wr({2'b10, 6'(20 + i), 5'd0, 9'd5, 10'(i)});
    @(negedge clk); cmd_wr = 1'b0;
    pl_idle = 1'b1;
    @(negedge clk); pl_idle = 1'b0;
    @(negedge clk);
    chk("rmo_cnt5", cmd_cnt, 5);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rmo_cnt", cmd_cnt, 0);
    chk("rmo_pulses", {add_img, rem_img, add_fnt}, 0);
    chk("rmo_busy", busy, 0);
    log_q.delete();
    pl_idle = 1'b1;
    repeat (10) @(negedge clk);
    chk("rmo_nopulse", log_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
